// File: rtl/kgp_fetch_pkg.sv
// -----------------------------------------------------------------------------
// kgp_fetch_pkg
//
// Purpose:
//   Shared definitions for the KGP_RISC instruction-fetch front end.
//
// Contents:
//   fetch_state_e      - fetch sequencer control state {FETCH, HALTED}
//   HALT_WORD_DEFAULT  - instruction encoding that stops fetch
//   RESET_PC_DEFAULT   - first word address fetched after reset
// -----------------------------------------------------------------------------
package kgp_fetch_pkg;

    // FETCH : issuing one read per cycle unless stalled or redirected.
    // HALTED: a halt word was captured; nothing is issued until a redirect.
    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam int unsigned RESET_PC_DEFAULT  = 0;

endpackage : kgp_fetch_pkg

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Purpose:
//   Initiator side of the instruction-fetch interface. Generates the word
//   address driven to a synchronous-read instruction memory (1-cycle latency),
//   captures the returned word into an output register and presents it to
//   decode. Handles branch/jump redirects and halt-word detection.
//
// Ports:
//   clk            in   single clock, all state updates on posedge
//   rst            in   synchronous active-high reset
//   pc             out  address to the instruction memory
//   instruction    in   memory data, equals mem[pc of previous cycle]
//   ir             out  instruction presented to decode
//   ir_pc          out  word address of ir
//   ir_valid       out  ir / ir_pc valid
//   ir_ready       in   decode accepts ir this cycle
//   redirect_valid in   branch/jump taken: flush and refetch from redirect_pc
//   redirect_pc    in   redirect target
//   halted         out  high while the sequencer is in HALTED
//   retire_count   out  number of ir_valid && ir_ready handshakes (wraps)
//
// Handshake:
//   ir/ir_pc transfer to decode on any rising edge where ir_valid && ir_ready.
//   While ir_valid is high and ir_ready is low, ir, ir_pc and ir_valid hold
//   their values; ir_valid never depends combinationally on ir_ready.
//   A redirect (or reset) withdraws ir_valid; a transfer that completes in the
//   redirect cycle is still counted.
// -----------------------------------------------------------------------------
module fetch_sequencer
    import kgp_fetch_pkg::*;
#(
    parameter int unsigned           PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC  = PC_WIDTH'(RESET_PC_DEFAULT),
    parameter logic [31:0]           HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PC_WIDTH-1:0] pc,
    input  logic [31:0]         instruction,
    output logic [31:0]         ir,
    output logic [PC_WIDTH-1:0] ir_pc,
    output logic                ir_valid,
    input  logic                ir_ready,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                halted,
    output logic [PC_WIDTH-1:0] retire_count
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    fetch_state_e          state_q,      state_d;
    logic [PC_WIDTH-1:0]   fetch_pc_q,   fetch_pc_d;    // next address to issue
    logic                  mem_valid_q,  mem_valid_d;   // read in flight, data on instruction now
    logic [PC_WIDTH-1:0]   mem_pc_q,     mem_pc_d;      // address of that read
    logic [31:0]           ir_q,         ir_d;
    logic [PC_WIDTH-1:0]   ir_pc_q,      ir_pc_d;
    logic                  ir_valid_q,   ir_valid_d;
    logic [PC_WIDTH-1:0]   retire_q,     retire_d;

    // Per-cycle control terms
    logic stall;       // decode is holding the current ir
    logic issue;       // a new read is launched this cycle
    logic capture;     // the in-flight read is loaded into ir this cycle
    logic handshake;   // decode takes ir this cycle

    always_comb begin
        stall     = ir_valid_q && !ir_ready;
        issue     = (state_q == FETCH) && !stall && !redirect_valid;
        capture   = mem_valid_q && !stall && !redirect_valid;
        handshake = ir_valid_q && ir_ready;
    end

    // -------------------------------------------------------------------------
    // Memory address. While stalled the memory re-reads the held word so the
    // data is still on instruction when the stall releases.
    // -------------------------------------------------------------------------
    always_comb begin
        if (stall && mem_valid_q) begin
            pc = mem_pc_q;
        end else begin
            pc = fetch_pc_q;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        mem_valid_d = mem_valid_q;
        mem_pc_d    = mem_pc_q;
        ir_d        = ir_q;
        ir_pc_d     = ir_pc_q;
        ir_valid_d  = ir_valid_q;
        retire_d    = retire_q;

        // Counted independently of redirect so a transfer in the redirect
        // cycle is not lost.
        if (handshake) begin
            retire_d = retire_q + PC_ONE;
        end

        if (redirect_valid) begin
            // Flush everything in flight and restart at the target; this is
            // also the only way out of HALTED.
            ir_valid_d  = 1'b0;
            mem_valid_d = 1'b0;
            fetch_pc_d  = redirect_pc;
            state_d     = FETCH;
        end else begin
            // Fetch side
            if (issue) begin
                fetch_pc_d  = fetch_pc_q + PC_ONE;
                mem_valid_d = 1'b1;
                mem_pc_d    = fetch_pc_q;
            end else if (!stall) begin
                mem_valid_d = 1'b0;
            end

            // Output register side
            if (capture) begin
                ir_d       = instruction;
                ir_pc_d    = mem_pc_q;
                ir_valid_d = 1'b1;
                if (instruction == HALT_WORD) begin
                    // The halt word itself is delivered; the read issued in
                    // this same cycle is discarded.
                    state_d     = HALTED;
                    mem_valid_d = 1'b0;
                end
            end else if (handshake) begin
                ir_valid_d = 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            fetch_pc_q  <= RESET_PC;
            mem_valid_q <= 1'b0;
            mem_pc_q    <= '0;
            ir_q        <= '0;
            ir_pc_q     <= '0;
            ir_valid_q  <= 1'b0;
            retire_q    <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            mem_valid_q <= mem_valid_d;
            mem_pc_q    <= mem_pc_d;
            ir_q        <= ir_d;
            ir_pc_q     <= ir_pc_d;
            ir_valid_q  <= ir_valid_d;
            retire_q    <= retire_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign ir           = ir_q;
    assign ir_pc        = ir_pc_q;
    assign ir_valid     = ir_valid_q;
    assign halted       = (state_q == HALTED);
    assign retire_count = retire_q;

endmodule : fetch_sequencer
